seq_det_word_scan_ctrl: RTL
===========================

// Module: seq_det_word_scan_ctrl
// PURPOSE
//  Scheduler/controller that feeds parallel words, one bit per cycle MSB-first, into an embedded
//  overlapping Moore "1010" detector (states S0,S1,S10,S101,S1010) and reports detections per word.
//  Sits between a word-wide producer (valid/ready) and a consumer of per-word hit results.
//  Lets the team run the serial detector on packed data without an external shifter or counter.
// PARAMETERS
//  WORD_W      8  bits per word; must be >= 4
//  CNT_W       4  width of Out_Count; must hold WORD_W/2
//  CARRY_STATE 0  0: detector state reset to S0 at each word accept; 1: state carried across words
// PORTS
//  Clk        in   1       clock; all state updates on rising edge
//  Rst        in   1       asynchronous, active-high reset
//  Clr        in   1       synchronous abort: to IDLE, detector to S0, results cleared
//  In_Valid   in   1       producer has a word on In_Word
//  In_Ready   out  1       controller can accept a word (high only in IDLE)
//  In_Word    in   WORD_W  word to scan; bit WORD_W-1 is sent first
//  Out_Valid  out  1       result registers valid (REPORT state)
//  Out_Ready  in   1       consumer takes result
//  Out_Count  out  CNT_W   number of detections completed within the word
//  Out_Mask   out  WORD_W  bit i set if a detection completed on word bit i
//  Busy       out  1       high in SHIFT or REPORT
//  Det_State  out  3       current embedded detector state (debug): S0=0,S1=1,S10=2,S101=3,S1010=4
// BEHAVIOUR
//  Reset (Rst=1, async): ctrl=IDLE, detector=S0, shift reg, bit index, Out_Count, Out_Mask = 0.
//   Outputs during/after reset: In_Ready=1, Out_Valid=0, Busy=0, Det_State=0.
//  Control FSM: IDLE -> SHIFT -> REPORT -> IDLE.
//   IDLE:   In_Ready=1. On In_Valid at edge T0: latch In_Word, idx=WORD_W-1,
//           Out_Count=0, Out_Mask=0; if CARRY_STATE=0, detector=S0. Go to SHIFT.
//   SHIFT:  each edge consumes bit b=word[idx]; detector steps:
//           S0:b?S1:S0  S1:b?S1:S10  S10:b?S101:S0  S101:b?S1:S1010  S1010:b?S101:S0
//           Detection = next state S1010: Out_Count+=1, Out_Mask[idx]=1.
//           Overlap is allowed. idx decrements; the edge consuming idx=0 moves to REPORT.
//           Edges T0+1..T0+WORD_W consume the bits; Out_Valid=1 from edge T0+WORD_W.
//   REPORT: Out_Valid=1; Out_Count and Out_Mask hold stable while Out_Ready=0.
//           Edge with Out_Ready=1: go to IDLE, Out_Valid=0.
//           Next accept is no earlier than the following edge (no same-cycle turnaround).
//  Detector state persists through REPORT/IDLE. CARRY_STATE=1 uses it as the start of the next word.
//  Out_Count never wraps (CNT_W sized by parameter rule). Out_Count/Out_Mask keep last result in IDLE.
//  Clr priority below Rst, above all else, in any state:
//   next edge gives IDLE, detector S0, Count/Mask 0, Out_Valid 0. Any in-flight word is dropped.
//  In_Valid is ignored outside IDLE. In_Word is sampled only at the accept edge.
//  Rst mid-SHIFT/REPORT: immediate return to reset values; the partial result is lost.
// TESTING (WORD_W=8, CNT_W=4)
//  Accept 8'hAA, Out_Ready=1 -> Out_Valid exactly 8 edges after accept, Count=3, Mask=8'h15.
//  Accept 8'hFF then 8'h0A -> Count=0/Mask=8'h00, then Count=1/Mask=8'h01.
//  CARRY_STATE=1: 8'h05 then 8'h00 -> 2nd word Count=1, Mask=8'h80; CARRY_STATE=0: 2nd Count=0.
//  Out_Ready low 5 cycles in REPORT -> Out_Valid, Count, Mask stable; In_Ready=0; In_Valid ignored.
//  Rst or Clr pulse on 4th SHIFT cycle of 8'hAA -> In_Ready=1, Out_Valid=0, Det_State=0; next word ok.
//  Back-to-back In_Valid held high with Out_Ready=1 -> one word per 10 cycles, all results correct.

Source files
------------

// File: rtl/seq_det_word_scan_ctrl.sv
// Word-to-serial scan controller wrapping an overlapping Moore "1010" detector.
// Each accepted word is fed MSB-first, one bit per clock, and per-word hits are reported.
module seq_det_word_scan_ctrl #(
    parameter int WORD_W      = 8,
    parameter int CNT_W       = 4,
    parameter int CARRY_STATE = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Clr,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [WORD_W-1:0] In_Word,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CNT_W-1:0]  Out_Count,
    output logic [WORD_W-1:0] Out_Mask,
    output logic              Busy,
    output logic [2:0]        Det_State
);

    localparam int IDX_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } ctrl_t;

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1010 = 3'd4
    } det_t;

    ctrl_t             ctrl;
    det_t              det;
    det_t              det_next;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              bit_in;

    always_comb begin
        bit_in   = word[idx];
        det_next = S0;
        unique case (det)
            S0:      det_next = bit_in ? S1   : S0;
            S1:      det_next = bit_in ? S1   : S10;
            S10:     det_next = bit_in ? S101 : S0;
            S101:    det_next = bit_in ? S1   : S1010;
            S1010:   det_next = bit_in ? S101 : S0;
            default: det_next = S0;
        endcase
    end

    assign Det_State = det;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ctrl      <= IDLE;
            det       <= S0;
            word      <= '0;
            idx       <= '0;
            Out_Count <= '0;
            Out_Mask  <= '0;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
        end else if (Clr) begin
            ctrl      <= IDLE;
            det       <= S0;
            word      <= '0;
            idx       <= '0;
            Out_Count <= '0;
            Out_Mask  <= '0;
            In_Ready  <= 1'b1;
            Out_Valid <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            unique case (ctrl)
                IDLE: begin
                    if (In_Valid) begin
                        word      <= In_Word;
                        idx       <= IDX_W'(WORD_W - 1);
                        Out_Count <= '0;
                        Out_Mask  <= '0;
                        if (CARRY_STATE == 0) begin
                            det <= S0;
                        end
                        In_Ready  <= 1'b0;
                        Busy      <= 1'b1;
                        ctrl      <= SHIFT;
                    end
                end
                SHIFT: begin
                    det <= det_next;
                    // A hit is credited to the word bit that completed the pattern.
                    if (det_next == S1010) begin
                        Out_Count     <= Out_Count + 1'b1;
                        Out_Mask[idx] <= 1'b1;
                    end
                    if (idx == '0) begin
                        Out_Valid <= 1'b1;
                        ctrl      <= REPORT;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                REPORT: begin
                    if (Out_Ready) begin
                        Out_Valid <= 1'b0;
                        Busy      <= 1'b0;
                        In_Ready  <= 1'b1;
                        ctrl      <= IDLE;
                    end
                end
                default: begin
                    ctrl      <= IDLE;
                    In_Ready  <= 1'b1;
                    Out_Valid <= 1'b0;
                    Busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
